instruction_sequencer: RTL
==========================

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8, width of address/instruction words.
REQ-002 SHALL have parameter STACK_DEPTH, default 4, return-stack entries (used only with CALL_STACK_EN).
REQ-003 clock  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high; one clock, synchronous reset only.
REQ-005 run  input  1  leaves IDLE when high.
REQ-006 pc_value  input  WORD_WIDTH  current program_counter result.
REQ-007 zero_flag  input  1  ALU zero flag.
REQ-008 mem_read  output  1  instruction-memory read request.
REQ-009 mem_addr  output  WORD_WIDTH  read address.
REQ-010 mem_ready  input  1  read data valid this cycle.
REQ-011 mem_data  input  WORD_WIDTH  instruction word; opcode = mem_data[WORD_WIDTH-1 -: 4].
REQ-012 pc_enable, pc_jump, pc_jz  output  1 each  program_counter strobes.
REQ-013 pc_jump_address  output  WORD_WIDTH  jump target.
REQ-014 alu_op  output  4  ALU operation; alu_valid  output  1  one-cycle ALU issue pulse.
REQ-015 halted  output  1  high in HALT; stack_fault  output  1  sticky stack error.

Function
REQ-016 States SHALL be IDLE, FETCH, DECODE, OPERAND, EXECUTE, HALT.
REQ-017 IDLE -> FETCH on run=1; else stay.
REQ-018 FETCH: mem_read=1, mem_addr=pc_value; on mem_ready=1 latch instruction, pulse pc_enable (jump/jz low), -> DECODE; else hold.
REQ-019 DECODE (1 cycle, no strobes): opcodes 0x8 JMP, 0x9 JZ, 0xA CALL -> OPERAND; all others -> EXECUTE.
REQ-020 OPERAND: as FETCH but latch target word; on mem_ready pulse pc_enable, -> EXECUTE.
REQ-021 EXECUTE, 0x1-0x7: alu_valid=1, alu_op=opcode, -> FETCH.
REQ-022 EXECUTE, JMP: pc_enable=1, pc_jump=1, pc_jump_address=target, -> FETCH.
REQ-023 EXECUTE, JZ: if zero_flag=1 then pc_enable=1, pc_jz=1, pc_jump_address=target; if 0, no PC strobe; -> FETCH.
REQ-024 EXECUTE, 0xF HLT -> HALT; 0x0 and undefined opcodes -> FETCH with no strobes.
REQ-025 HALT SHALL persist until reset; halted=1, all strobes 0, run ignored.
REQ-026 Strobes (pc_*, alu_valid) SHALL be single-cycle; at most one of pc_jump/pc_jz high.
REQ-027 Minimum latency with mem_ready=1: 3 cycles per single-word instruction, 4 per two-word.
REQ-028 mem_data SHALL be sampled only in a cycle with mem_read=1 and mem_ready=1.

Reset
REQ-029 reset=1 at any edge, mid-fetch included, SHALL force IDLE, clear latched instruction/target, stack pointer and stack_fault.
REQ-030 During and after reset all outputs SHALL be 0 (mem_addr, pc_jump_address, alu_op = 0).

Configuration
REQ-031 Macro CALL_STACK_EN SHALL enable a STACK_DEPTH-entry return stack.
REQ-032 With CALL_STACK_EN, CALL SHALL push pc_value (return address) and jump as JMP; RET (0xB) SHALL pop and jump to popped address.
REQ-033 With CALL_STACK_EN, CALL when full or RET when empty SHALL set stack_fault=1, issue no strobe, enter HALT.
REQ-034 Without CALL_STACK_EN, 0xA and 0xB SHALL decode as single-word NOPs; stack_fault tied 0.

Verification
REQ-035 Reset then run=1, mem_ready=1, mem_data=0x30 -> alu_op=3, alu_valid pulse 3 cycles after run, one pc_enable pulse.
REQ-036 JMP 0x80 then 0x42 -> two pc_enable fetch pulses, then pc_jump=1 with pc_jump_address=0x42.
REQ-037 JZ 0x90/0x10, zero_flag=0 then repeat with 1 -> no jump strobe first; pc_jz=1, address 0x10 second.
REQ-038 mem_ready held 0 for 5 cycles in FETCH -> mem_read stays 1, no strobes, state unchanged.
REQ-039 HLT 0xF0 -> halted=1 persists 20 cycles despite run=1; reset clears to IDLE, outputs 0.
REQ-040 CALL_STACK_EN: 5 nested CALLs (STACK_DEPTH=4) -> 5th sets stack_fault=1, halted=1; RET after 1 CALL returns to pushed address.

Source files
------------

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - fetch/decode/execute sequencer driving a program counter and ALU.
// Optional return stack for CALL/RET is built when CALL_STACK_EN is defined.
module instruction_sequencer #(
    parameter int WORD_WIDTH  = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
    input  logic [WORD_WIDTH-1:0] pc_value,
    input  logic                  zero_flag,
    output logic                  mem_read,
    output logic [WORD_WIDTH-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic [WORD_WIDTH-1:0] mem_data,
    output logic                  pc_enable,
    output logic                  pc_jump,
    output logic                  pc_jz,
    output logic [WORD_WIDTH-1:0] pc_jump_address,
    output logic [3:0]            alu_op,
    output logic                  alu_valid,
    output logic                  halted,
    output logic                  stack_fault
);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, OPERAND, EXECUTE, HALT
    } state_t;

    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t                state;
    logic [3:0]            opcode;
    logic [WORD_WIDTH-1:0] target;
    logic                  two_word;

`ifdef CALL_STACK_EN
    localparam logic [3:0] OP_CALL = 4'hA;
    localparam logic [3:0] OP_RET  = 4'hB;
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [WORD_WIDTH-1:0] stack [STACK_DEPTH];
    logic [SP_W-1:0]       sp;
    logic [SP_W-1:0]       sp_dec;
    logic                  fault;
    logic                  stack_full;
    logic                  stack_empty;

    assign sp_dec      = sp - SP_W'(1);
    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp == '0);
    assign two_word    = (opcode == OP_JMP) || (opcode == OP_JZ) || (opcode == OP_CALL);
`else
    assign two_word    = (opcode == OP_JMP) || (opcode == OP_JZ);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            opcode <= '0;
            target <= '0;
`ifdef CALL_STACK_EN
            sp     <= '0;
            fault  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (run) state <= FETCH;
                FETCH: begin
                    if (mem_ready) begin
                        opcode <= mem_data[WORD_WIDTH-1 -: 4];
                        state  <= DECODE;
                    end
                end
                DECODE: state <= two_word ? OPERAND : EXECUTE;
                OPERAND: begin
                    if (mem_ready) begin
                        target <= mem_data;
                        state  <= EXECUTE;
                    end
                end
                EXECUTE: begin
                    state <= (opcode == OP_HLT) ? HALT : FETCH;
`ifdef CALL_STACK_EN
                    // pc_value already points past the operand word: that is the return address
                    if (opcode == OP_CALL) begin
                        if (stack_full) begin
                            fault <= 1'b1;
                            state <= HALT;
                        end else begin
                            stack[sp[IDX_W-1:0]] <= pc_value;
                            sp <= sp + SP_W'(1);
                        end
                    end
                    if (opcode == OP_RET) begin
                        if (stack_empty) begin
                            fault <= 1'b1;
                            state <= HALT;
                        end else begin
                            sp <= sp_dec;
                        end
                    end
`endif
                end
                HALT: state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_read        = 1'b0;
        mem_addr        = '0;
        pc_enable       = 1'b0;
        pc_jump         = 1'b0;
        pc_jz           = 1'b0;
        pc_jump_address = '0;
        alu_op          = '0;
        alu_valid       = 1'b0;
        halted          = 1'b0;
        if (!reset) begin
            case (state)
                FETCH, OPERAND: begin
                    mem_read  = 1'b1;
                    mem_addr  = pc_value;
                    pc_enable = mem_ready;
                end
                EXECUTE: begin
                    case (opcode)
                        4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                            alu_valid = 1'b1;
                            alu_op    = opcode;
                        end
                        OP_JMP: begin
                            pc_enable       = 1'b1;
                            pc_jump         = 1'b1;
                            pc_jump_address = target;
                        end
                        OP_JZ: begin
                            if (zero_flag) begin
                                pc_enable       = 1'b1;
                                pc_jz           = 1'b1;
                                pc_jump_address = target;
                            end
                        end
`ifdef CALL_STACK_EN
                        OP_CALL: begin
                            if (!stack_full) begin
                                pc_enable       = 1'b1;
                                pc_jump         = 1'b1;
                                pc_jump_address = target;
                            end
                        end
                        OP_RET: begin
                            if (!stack_empty) begin
                                pc_enable       = 1'b1;
                                pc_jump         = 1'b1;
                                pc_jump_address = stack[sp_dec[IDX_W-1:0]];
                            end
                        end
`endif
                        default: ;
                    endcase
                end
                HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef CALL_STACK_EN
    assign stack_fault = fault & ~reset;
`else
    assign stack_fault = 1'b0;
`endif

endmodule
